// File: rtl/life_pkg.sv
// Shared board geometry, FSM state type and small helpers for the Game-of-Life engine.
package life_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    SWAP
  } state_t;

  function automatic int idx_to_x(input logic [IDX_W-1:0] idx);
    return int'(idx) % GRID_W;
  endfunction

  function automatic int idx_to_y(input logic [IDX_W-1:0] idx);
    return int'(idx) / GRID_W;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [CELLS-1:0] board);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < CELLS; i++) begin
      c = c + CNT_W'(board[IDX_W'(i)]);
    end
    return c;
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// Control and display-read bundle between the frame timing / VGA stage and the life engine.
interface life_engine_if;
  import life_pkg::*;

  // frame_tick, step and seed_load are single-cycle pulses sampled on the rising clk
  // edge; there is no back-pressure, the engine always accepts them (frame_tick is
  // simply dropped while busy). rd_idx -> rd_cell is a same-cycle combinational read.
  logic                 frame_tick;
  logic                 pause;
  logic                 step;
  logic                 seed_load;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_cell;
  logic                 busy;
  logic                 gen_done;
  logic [15:0]          gen_count;
  logic [CNT_W-1:0]     live_count;
  state_t               state;

  modport master (
    output frame_tick, pause, step, seed_load, rd_idx,
    input  rd_cell, busy, gen_done, gen_count, live_count, state
  );

  modport slave (
    input  frame_tick, pause, step, seed_load, rd_idx,
    output rd_cell, busy, gen_done, gen_count, live_count, state
  );

endinterface

// File: rtl/life_neighbour_count.sv
// Counts live neighbours of one cell; cells beyond the board edge are treated as dead.
module life_neighbour_count
  import life_pkg::*;
(
  input  logic [CELLS-1:0] board_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [3:0]       count_o
);

  int cx;
  int cy;

  always_comb begin
    count_o = '0;
    cx      = idx_to_x(idx_i);
    cy      = idx_to_y(idx_i);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        // No wrap-around: off-board positions contribute nothing.
        if ((dx != 0 || dy != 0) &&
            (cx + dx >= 0) && (cx + dx < GRID_W) &&
            (cy + dy >= 0) && (cy + dy < GRID_H)) begin
          count_o = count_o + 4'(board_i[IDX_W'((cy + dy) * GRID_W + cx + dx)]);
        end
      end
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life generation engine: sequential one-cell-per-clock update during vblank,
// atomic board swap, zero-latency display read port.
module life_engine
  import life_pkg::*;
#(
  parameter int               GEN_FRAMES = 60,
  parameter logic [CELLS-1:0] SEED       = '0
) (
  input  logic   clk,
  input  logic   reset,
  life_engine_if.slave bus
);

  localparam logic [CNT_W-1:0] SEED_POP   = popcount(SEED);
  localparam logic [5:0]       LAST_FRAME = 6'(GEN_FRAMES - 1);

  state_t           state_q;
  logic [CELLS-1:0] cur_q;
  logic [CELLS-1:0] nxt_q;
  logic [IDX_W-1:0] idx_q;
  logic [5:0]       frame_cnt_q;
  logic             step_pending_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] live_count_q;
  logic [15:0]      gen_count_q;
  logic             gen_done_q;

  logic [3:0]       n_count;
  logic             new_cell_d;
  logic             start_gen_d;

  life_neighbour_count u_nbr (
    .board_i (cur_q),
    .idx_i   (idx_q),
    .count_o (n_count)
  );

  assign new_cell_d  = (n_count == 4'd3) | (cur_q[idx_q] & (n_count == 4'd2));
  assign start_gen_d = (state_q == IDLE) && bus.frame_tick &&
                       (bus.pause ? step_pending_q : (frame_cnt_q == LAST_FRAME));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cur_q          <= SEED;
      nxt_q          <= '0;
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      step_pending_q <= 1'b0;
      acc_q          <= '0;
      live_count_q   <= SEED_POP;
      gen_count_q    <= '0;
      gen_done_q     <= 1'b0;
    end else if (bus.seed_load) begin
      // Aborts any generation in flight; the work buffer is simply left stale.
      state_q        <= IDLE;
      cur_q          <= SEED;
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      step_pending_q <= 1'b0;
      acc_q          <= '0;
      live_count_q   <= SEED_POP;
      gen_count_q    <= '0;
      gen_done_q     <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      if (bus.step) begin
        step_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.frame_tick && !bus.pause) begin
            frame_cnt_q <= (frame_cnt_q == LAST_FRAME) ? 6'd0 : frame_cnt_q + 6'd1;
          end
          if (start_gen_d) begin
            state_q        <= COMPUTE;
            idx_q          <= '0;
            acc_q          <= '0;
            step_pending_q <= 1'b0;
          end
        end
        COMPUTE: begin
          nxt_q[idx_q] <= new_cell_d;
          acc_q        <= acc_q + CNT_W'(new_cell_d);
          idx_q        <= idx_q + 1'b1;
          if (idx_q == IDX_W'(CELLS - 1)) begin
            state_q <= SWAP;
          end
        end
        SWAP: begin
          cur_q        <= nxt_q;
          live_count_q <= acc_q;
          gen_count_q  <= gen_count_q + 16'd1;
          gen_done_q   <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_cell    = (int'(bus.rd_idx) < CELLS) ? cur_q[bus.rd_idx] : 1'b0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.gen_done   = gen_done_q;
  assign bus.gen_count  = gen_count_q;
  assign bus.live_count = live_count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench: five engines with different seeds share one control stream and
// are compared against a whole-board reference model.
module tb_life_engine;
  import life_pkg::*;

  localparam int NI = 5;
  localparam int GF = 2;
  localparam logic [255:0] B1 = 256'd1;
  localparam logic [255:0] SEEDS [NI] = '{
    (B1 << 118) | (B1 << 119) | (B1 << 120),
    (B1 << 0) | (B1 << 1) | (B1 << 16) | (B1 << 17),
    (B1 << 1) | (B1 << 2) | (B1 << 3),
    (B1 << 1) | (B1 << 18) | (B1 << 32) | (B1 << 33) | (B1 << 34),
    256'h3c5a_0000_8181_0f00_00f0_6600_0018_a5a5_5a00_0c30_0000_7e00_1248_0000_e007_0990
  };
  localparam logic [255:0] BLINK_V  = (B1 << 103) | (B1 << 119) | (B1 << 135);
  localparam logic [255:0] EDGE_1   = (B1 << 2) | (B1 << 18);
  localparam logic [255:0] GLIDER_4 = (B1 << 18) | (B1 << 35) | (B1 << 49) | (B1 << 50) | (B1 << 51);

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       pause;
  logic       step;
  logic       seed_load;
  logic [7:0] rd_idx;

  logic        rd_cell_v    [NI];
  logic        busy_v       [NI];
  logic        gen_done_v   [NI];
  logic [15:0] gen_count_v  [NI];
  logic [8:0]  live_count_v [NI];
  state_t      state_v      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    life_engine_if ifc ();
    assign ifc.frame_tick   = frame_tick;
    assign ifc.pause        = pause;
    assign ifc.step         = step;
    assign ifc.seed_load    = seed_load;
    assign ifc.rd_idx       = rd_idx;
    assign rd_cell_v[g]     = ifc.rd_cell;
    assign busy_v[g]        = ifc.busy;
    assign gen_done_v[g]    = ifc.gen_done;
    assign gen_count_v[g]   = ifc.gen_count;
    assign live_count_v[g]  = ifc.live_count;
    assign state_v[g]       = ifc.state;
    life_engine #(.GEN_FRAMES(GF), .SEED(SEEDS[g])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
    );
  end

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #900000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Reference model state
  logic [255:0] m_board [NI];
  int           m_gen;
  int           m_fcnt;
  bit           m_pend;
  logic [15:0]  exp_q[$];
  logic [255:0] dut_board [NI];
  int           last_lat;

  function automatic logic [255:0] life_next(input logic [255:0] b);
    int pad [18][18];
    logic [255:0] r;
    int s;
    for (int y = 0; y < 18; y++)
      for (int x = 0; x < 18; x++) pad[y][x] = 0;
    for (int i = 0; i < 256; i++) pad[i / 16 + 1][i % 16 + 1] = b[8'(i)] ? 1 : 0;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      s = -pad[i / 16 + 1][i % 16 + 1];
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++) s += pad[i / 16 + dy][i % 16 + dx];
      r[8'(i)] = (s == 3) || (b[8'(i)] && s == 2);
    end
    return r;
  endfunction

  function automatic bit m_tick(input logic p);
    bit gen;
    gen = 1'b0;
    if (!p) begin
      if (m_fcnt == GF - 1) begin
        m_fcnt = 0;
        gen = 1'b1;
      end else begin
        m_fcnt++;
      end
    end else if (m_pend) begin
      gen = 1'b1;
    end
    if (gen) m_pend = 1'b0;
    return gen;
  endfunction

  task automatic m_reseed();
    for (int g = 0; g < NI; g++) m_board[g] = SEEDS[g];
    m_gen = 0;
    m_fcnt = 0;
    m_pend = 1'b0;
  endtask

  task automatic m_advance();
    for (int g = 0; g < NI; g++) m_board[g] = life_next(m_board[g]);
    m_gen++;
  endtask

  // Checking helpers
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_boards();
    for (int i = 0; i < 256; i++) begin
      rd_idx = 8'(i);
      #1;
      for (int g = 0; g < NI; g++) dut_board[g][8'(i)] = rd_cell_v[g];
    end
    rd_idx = 8'd0;
    cyc(1);
  endtask

  task automatic check_all(input string tag);
    read_boards();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s board[%0d]", tag, g), dut_board[g], m_board[g]);
      check($sformatf("%s live_count[%0d]", tag, g), 256'(live_count_v[g]), 256'($countones(m_board[g])));
      check($sformatf("%s gen_count[%0d]", tag, g), 256'(gen_count_v[g]), 256'(16'(m_gen)));
    end
  endtask

  // Driver tasks
  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic do_seed_load();
    seed_load = 1'b1;
    cyc(1);
    seed_load = 1'b0;
    m_reseed();
  endtask

  task automatic wait_gen();
    last_lat = 0;
    while (!gen_done_v[0] && last_lat < 400) begin
      cyc(1);
      last_lat++;
    end
    if (!gen_done_v[0]) check("gen_done within 400 cycles", 256'(0), 256'(1));
    else if (exp_q.size() > 0) check("gen_count at gen_done", 256'(gen_count_v[0]), 256'(exp_q.pop_front()));
  endtask

  task automatic do_frame(input logic p);
    bit gen_exp;
    pause = p;
    gen_exp = m_tick(p);
    if (gen_exp) exp_q.push_back(16'(m_gen + 1));
    pulse_tick();
    check("busy after frame_tick", 256'(busy_v[0]), 256'(gen_exp));
    if (busy_v[0]) wait_gen();
    if (gen_exp) m_advance();
  endtask

  typedef struct {
    logic pause;
    logic step;
    int   ticks;
    int   exp_gens;
  } vec_t;

  vec_t tbl [10];
  logic [15:0] g0;
  int seen;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2,   1};
    tbl[1] = '{1'b0, 1'b0, 1,   0};
    tbl[2] = '{1'b0, 1'b0, 1,   1};
    tbl[3] = '{1'b1, 1'b0, 200, 0};
    tbl[4] = '{1'b1, 1'b1, 1,   1};
    tbl[5] = '{1'b1, 1'b0, 3,   0};
    tbl[6] = '{1'b1, 1'b1, 2,   1};
    tbl[7] = '{1'b0, 1'b0, 4,   2};
    tbl[8] = '{1'b0, 1'b0, 3,   1};
    tbl[9] = '{1'b0, 1'b0, 1,   1};

    reset = 1'b1;
    frame_tick = 1'b0;
    pause = 1'b0;
    step = 1'b0;
    seed_load = 1'b0;
    rd_idx = 8'd0;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // Reset state
    m_reseed();
    check("reset busy", 256'(busy_v[0]), 256'(0));
    check("reset gen_done", 256'(gen_done_v[0]), 256'(0));
    check("reset state", 256'(state_v[0]), 256'(IDLE));
    check_all("reset");

    // Blinker / edge blinker / corner block, first generation and latency
    do_frame(1'b0);
    do_frame(1'b0);
    check("latency tick to gen_done", 256'(last_lat), 256'(257));
    cyc(1);
    check("gen_done single cycle", 256'(gen_done_v[0]), 256'(0));
    check_all("gen1");
    check("blinker vertical", dut_board[0], BLINK_V);
    check("top-edge blinker", dut_board[2], EDGE_1);
    check("corner block still", dut_board[1], SEEDS[1]);
    check("top-edge live_count", 256'(live_count_v[2]), 256'(2));
    do_frame(1'b0);
    do_frame(1'b0);
    check_all("gen2");
    check("blinker back horizontal", dut_board[0], SEEDS[0]);
    for (int i = 0; i < 4; i++) do_frame(1'b0);
    check_all("gen4");
    check("glider shifted", dut_board[3], GLIDER_4);
    check("glider live_count", 256'(live_count_v[3]), 256'(5));
    check("corner block after 4", dut_board[1], SEEDS[1]);

    // frame_tick during COMPUTE is ignored
    do_frame(1'b0);
    pause = 1'b0;
    void'(m_tick(1'b0));
    exp_q.push_back(16'(m_gen + 1));
    pulse_tick();
    check("state in COMPUTE", 256'(state_v[0]), 256'(COMPUTE));
    cyc(50);
    pulse_tick();
    wait_gen();
    m_advance();
    do_frame(1'b0);
    do_frame(1'b0);
    check_all("busy tick");

    // seed_load 100 cycles into COMPUTE
    do_frame(1'b0);
    pulse_tick();
    cyc(99);
    seed_load = 1'b1;
    cyc(1);
    seed_load = 1'b0;
    exp_q.delete();
    m_reseed();
    check("busy after seed_load", 256'(busy_v[0]), 256'(0));
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (gen_done_v[0]) seen++;
    end
    check("no gen_done after abort", 256'(seen), 256'(0));
    check_all("seed_load abort");

    // seed_load wins over simultaneous frame_tick and step
    do_frame(1'b0);
    frame_tick = 1'b1;
    step = 1'b1;
    seed_load = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    step = 1'b0;
    seed_load = 1'b0;
    m_reseed();
    check("busy after seed_load+tick", 256'(busy_v[0]), 256'(0));
    do_frame(1'b1);
    do_frame(1'b0);
    do_frame(1'b0);
    check_all("seed_load priority");

    // Reset mid-COMPUTE
    do_frame(1'b0);
    pulse_tick();
    cyc(50);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    exp_q.delete();
    m_reseed();
    check("busy after reset", 256'(busy_v[0]), 256'(0));
    check_all("reset mid-compute");

    // Table-driven pause/step/frame sequences
    do_seed_load();
    for (int r = 0; r < 10; r++) begin
      g0 = gen_count_v[0];
      if (tbl[r].step) do_step();
      for (int t = 0; t < tbl[r].ticks; t++) do_frame(tbl[r].pause);
      check($sformatf("row %0d generations", r), 256'(16'(gen_count_v[0] - g0)), 256'(tbl[r].exp_gens));
      check_all($sformatf("row %0d", r));
    end

    // Randomized pause/step/frame traffic
    for (int it = 0; it < 40; it++) begin
      pause = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) do_step();
      for (int t = 0; t < int'($urandom_range(1, 4)); t++) do_frame(pause);
      if (it % 4 == 3) check_all($sformatf("random %0d", it));
    end
    check_all("random end");

    // Final report
    check("scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
